instr_mem_arbiter: RTL and testbench

- Shares one single-port instruction BRAM among `N_CPU` `regex_cpu_pipelined` instances and a host write port.
- Each CPU fetch port (`memory_valid`/`memory_addr`/`memory_ready`/`memory_data`) connects to one requester slot. Grants are round-robin.
- Host writes have absolute priority. They are used to load a new regex program.
- The block sits between the CPU array and the instruction BRAM (1-cycle read latency) inside the regex engine.

---
 rtl/instr_mem_arbiter_if.sv | 40 ++++
 rtl/instr_mem_arbiter.sv | 98 +++++++++
 tb/tb_instr_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_arbiter_if : CPU fetch slots, host write port and BRAM bus bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface instr_mem_arbiter_if #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic                                 arb_enable;
  logic [N_CPU-1:0]                     cpu_mem_valid;
  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_mem_addr;
  logic [N_CPU-1:0]                     cpu_mem_ready;
  logic [MEMORY_WIDTH-1:0]              cpu_mem_data;
  logic                                 host_we;
  logic [MEMORY_ADDR_WIDTH-1:0]         host_addr;
  logic [MEMORY_WIDTH-1:0]              host_wdata;
  logic                                 bram_en;
  logic                                 bram_we;
  logic [MEMORY_ADDR_WIDTH-1:0]         bram_addr;
  logic [MEMORY_WIDTH-1:0]              bram_wdata;
  logic [MEMORY_WIDTH-1:0]              bram_dout;
  logic                                 pending;

  modport slave (
    input  arb_enable, cpu_mem_valid, cpu_mem_addr,
           host_we, host_addr, host_wdata, bram_dout,
    output cpu_mem_ready, cpu_mem_data,
           bram_en, bram_we, bram_addr, bram_wdata, pending
  );

  modport master (
    output arb_enable, cpu_mem_valid, cpu_mem_addr,
           host_we, host_addr, host_wdata, bram_dout,
    input  cpu_mem_ready, cpu_mem_data,
           bram_en, bram_we, bram_addr, bram_wdata, pending
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_arbiter : round-robin CPU fetch arbiter with priority host writes
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_mem_arbiter #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_arbiter_if.slave bus
);
  localparam int PW = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int MW = MEMORY_WIDTH;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_CPU-1:0] ready_q, ready_d;
  logic             en_q, en_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [MW-1:0]    wdata_q, wdata_d;

  logic [AW-1:0]    slot_addr [N_CPU];
  logic [N_CPU-1:0] eligible;
  logic             found;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    probe;

  for (genvar i = 0; i < N_CPU; i++) begin : g_slot
    assign slot_addr[i] = bus.cpu_mem_addr[i*AW +: AW];
  end

  // Masking by the live grant keeps a CPU that still holds valid in its
  // grant cycle from being accepted twice.
  always_comb begin
    eligible  = bus.cpu_mem_valid & ~ready_q;
    found     = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int k = 0; k < N_CPU; k++) begin
      probe = PW'((int'(rr_ptr_q) + k) % N_CPU);
      if (!found && eligible[probe]) begin
        found     = 1'b1;
        grant_idx = probe;
      end
    end
  end

  always_comb begin
    ready_d  = '0;
    en_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.host_we) begin
      we_d    = 1'b1;
      addr_d  = bus.host_addr;
      wdata_d = bus.host_wdata;
    end else if (bus.arb_enable && found) begin
      ready_d[grant_idx] = 1'b1;
      en_d               = 1'b1;
      addr_d             = slot_addr[grant_idx];
      rr_ptr_d           = PW'((int'(grant_idx) + 1) % N_CPU);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      ready_q  <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.cpu_mem_ready = ready_q;
  assign bus.bram_en       = en_q;
  assign bus.bram_we       = we_q;
  assign bus.bram_addr     = addr_q;
  assign bus.bram_wdata    = wdata_q;
  assign bus.cpu_mem_data  = bus.bram_dout;
  assign bus.pending       = |bus.cpu_mem_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_mem_arbiter : scoreboard bench for instr_mem_arbiter (N=4 and N=1)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_mem_arbiter;
  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_mem_arbiter_if #(.N_CPU(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) bus ();
  instr_mem_arbiter_if #(.N_CPU(1), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) bus1 ();

  instr_mem_arbiter #(.N_CPU(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  instr_mem_arbiter #(.N_CPU(1), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Single-port BRAMs with 1-cycle read latency
  logic [MW-1:0] mem0 [1<<AW];
  logic [MW-1:0] mem1 [1<<AW];
  always @(posedge clk) begin
    if (bus.bram_we)      mem0[bus.bram_addr] <= bus.bram_wdata;
    else if (bus.bram_en) bus.bram_dout       <= mem0[bus.bram_addr];
    if (bus1.bram_we)      mem1[bus1.bram_addr] <= bus1.bram_wdata;
    else if (bus1.bram_en) bus1.bram_dout       <= mem1[bus1.bram_addr];
  end

  typedef struct {
    int          cyc;
    bit          wr;
    int          cpu;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [MW-1:0] shadow [1<<AW];
  int            cyc    = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: for every accepted edge, what the arbiter must do next cycle
  int   m_ptr  = 0;
  int   m_last = -1;
  int   mg;
  exp_t me;
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_ptr  = 0;
      m_last = -1;
    end else begin
      cyc++;
      if (bus.host_we) begin
        me = '{cyc, 1'b1, -1, bus.host_addr, bus.host_wdata};
        q.push_back(me);
        shadow[bus.host_addr] = bus.host_wdata;
        m_last = -1;
      end else begin
        mg = -1;
        if (bus.arb_enable) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (mg < 0 && bus.cpu_mem_valid[idx] && idx != m_last) mg = idx;
          end
        end
        if (mg >= 0) begin
          me.cyc  = cyc;
          me.wr   = 1'b0;
          me.cpu  = mg;
          me.addr = bus.cpu_mem_addr[mg*AW +: AW];
          me.data = shadow[me.addr];
          q.push_back(me);
          m_ptr = (mg + 1) % N;
        end
        m_last = mg;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT shows an access
  exp_t          mo;
  bit            dpend = 1'b0;
  logic [MW-1:0] dexp;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      dpend = 1'b0;
      q.delete();
    end else begin
      if (dpend) begin
        chk("rd_data", 32'(bus.cpu_mem_data), 32'(dexp));
        dpend = 1'b0;
      end
      chk("pending", 32'(bus.pending), 32'(|bus.cpu_mem_valid));
      if (bus.cpu_mem_ready != '0 || bus.bram_we) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: ready=0x%0h we=%0b, expected none (cycle %0d)",
                   bus.cpu_mem_ready, bus.bram_we, cyc);
        end else begin
          mo = q.pop_front();
          chk("acc_cycle", 32'(cyc), 32'(mo.cyc));
          chk("acc_addr", 32'(bus.bram_addr), 32'(mo.addr));
          if (mo.wr) begin
            chk("wr_we", 32'(bus.bram_we), 32'd1);
            chk("wr_en", 32'(bus.bram_en), 32'd0);
            chk("wr_ready", 32'(bus.cpu_mem_ready), 32'd0);
            chk("wr_data", 32'(bus.bram_wdata), 32'(mo.data));
          end else begin
            chk("gnt_ready", 32'(bus.cpu_mem_ready), 32'd1 << mo.cpu);
            chk("gnt_en", 32'(bus.bram_en), 32'd1);
            chk("gnt_we", 32'(bus.bram_we), 32'd0);
            dexp  = mo.data;
            dpend = 1'b1;
          end
        end
      end else begin
        chk("idle_en", 32'(bus.bram_en), 32'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          mo = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_access: got idle, expected %s cpu=%0d addr=0x%0h (cycle %0d)",
                   mo.wr ? "write" : "grant", mo.cpu, mo.addr, cyc);
        end
      end
    end
  end

  // CPU behaviour: hold until granted, drop the cycle after, re-request after a cooldown
  bit gr   [N];
  int cool [N];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_step(input int cmax, input bit refill);
    for (int i = 0; i < N; i++) begin
      if (bus.cpu_mem_valid[i]) begin
        if (gr[i]) begin
          bus.cpu_mem_valid[i] = 1'b0;
          gr[i]   = 1'b0;
          cool[i] = int'($urandom_range(0, cmax));
        end else if (bus.cpu_mem_ready[i]) begin
          gr[i] = 1'b1;
        end
      end else if (cool[i] > 0) begin
        cool[i]--;
      end else if (refill) begin
        bus.cpu_mem_addr[i*AW +: AW] = AW'($urandom_range(0, 63));
        bus.cpu_mem_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic step_n(input int n, input int cmax, input bit refill);
    repeat (n) begin
      tick();
      cpu_step(cmax, refill);
    end
  endtask

  bit found;

  initial begin
    bus.arb_enable    = 1'b1;
    bus.cpu_mem_valid = '0;
    bus.cpu_mem_addr  = '0;
    bus.host_we       = 1'b0;
    bus.host_addr     = '0;
    bus.host_wdata    = '0;
    bus1.arb_enable    = 1'b1;
    bus1.cpu_mem_valid = '0;
    bus1.cpu_mem_addr  = '0;
    bus1.host_we       = 1'b0;
    bus1.host_addr     = '0;
    bus1.host_wdata    = '0;
    for (int i = 0; i < N; i++) begin
      gr[i]   = 1'b0;
      cool[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cpu_mem_ready), 32'd0);
    chk("rst_en", 32'(bus.bram_en), 32'd0);
    chk("rst_we", 32'(bus.bram_we), 32'd0);
    chk("rst_addr", 32'(bus.bram_addr), 32'd0);
    chk("rst_wdata", 32'(bus.bram_wdata), 32'd0);
    #1 rst = 1'b1;

    // Program load through the host port
    bus1.host_we    = 1'b1;
    bus1.host_addr  = AW'(5);
    bus1.host_wdata = 16'hBEEF;
    for (int a = 0; a < 64; a++) begin
      bus.host_we    = 1'b1;
      bus.host_addr  = AW'(a);
      bus.host_wdata = MW'($urandom);
      tick();
      bus1.host_we = 1'b0;
    end
    bus.host_we    = 1'b1;
    bus.host_addr  = AW'(12'h0DC);
    bus.host_wdata = 16'h1241;
    tick();
    bus.host_we = 1'b0;
    tick();

    // Single CPU request
    bus.cpu_mem_addr[2*AW +: AW] = AW'(12'h0DC);
    bus.cpu_mem_valid[2] = 1'b1;
    tick();
    chk("single_ready", 32'(bus.cpu_mem_ready), 32'h4);
    chk("single_addr", 32'(bus.bram_addr), 32'h0DC);
    tick();
    chk("single_data", 32'(bus.cpu_mem_data), 32'h1241);
    bus.cpu_mem_valid[2] = 1'b0;
    tick();
    // Pointer must now sit at 3
    bus.cpu_mem_valid[0] = 1'b1;
    bus.cpu_mem_valid[2] = 1'b1;
    bus.cpu_mem_valid[3] = 1'b1;
    tick();
    chk("rr_after_single", 32'(bus.cpu_mem_ready), 32'h8);
    cpu_step(0, 1'b0);
    step_n(12, 0, 1'b0);

    // Continuous round-robin
    step_n(40, 0, 1'b1);
    step_n(12, 0, 1'b0);

    // Host priority over a simultaneous CPU request
    bus.host_we    = 1'b1;
    bus.host_addr  = AW'(12'h100);
    bus.host_wdata = 16'h00FF;
    bus.cpu_mem_addr[1*AW +: AW] = AW'(12'h100);
    bus.cpu_mem_valid[1] = 1'b1;
    tick();
    chk("hp_we", 32'(bus.bram_we), 32'd1);
    chk("hp_no_grant", 32'(bus.cpu_mem_ready), 32'd0);
    bus.host_we = 1'b0;
    tick();
    chk("hp_grant", 32'(bus.cpu_mem_ready), 32'h2);
    tick();
    chk("hp_data", 32'(bus.cpu_mem_data), 32'h00FF);
    bus.cpu_mem_valid[1] = 1'b0;
    tick();

    // Enable gating
    bus.arb_enable = 1'b0;
    bus.cpu_mem_addr[0*AW +: AW] = AW'(7);
    bus.cpu_mem_addr[3*AW +: AW] = AW'(9);
    bus.cpu_mem_valid[0] = 1'b1;
    bus.cpu_mem_valid[3] = 1'b1;
    repeat (10) begin
      tick();
      chk("gate_ready", 32'(bus.cpu_mem_ready), 32'd0);
      chk("gate_pending", 32'(bus.pending), 32'd1);
    end
    bus.arb_enable = 1'b1;
    step_n(10, 0, 1'b0);

    // Asynchronous reset in the middle of a grant cycle
    bus.cpu_mem_addr[1*AW +: AW] = AW'(3);
    bus.cpu_mem_valid[1] = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (bus.cpu_mem_ready[1]) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rst_wait: got no grant to cpu1, expected one within 20 cycles");
    end else begin
      #2 rst = 1'b0;
      #1;
      chk("arst_ready", 32'(bus.cpu_mem_ready), 32'd0);
      chk("arst_en", 32'(bus.bram_en), 32'd0);
    end
    rst = 1'b0;
    bus.cpu_mem_valid = '0;
    for (int i = 0; i < N; i++) begin
      gr[i]   = 1'b0;
      cool[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    bus.cpu_mem_valid[1] = 1'b1;
    bus.cpu_mem_valid[2] = 1'b1;
    bus.cpu_mem_valid[3] = 1'b1;
    tick();
    chk("arst_first_grant", 32'(bus.cpu_mem_ready), 32'h2);
    cpu_step(0, 1'b0);
    step_n(10, 0, 1'b0);

    // Randomised traffic with host writes and enable toggling
    repeat (1500) begin
      tick();
      bus.host_we = ($urandom_range(0, 7) == 0);
      if (bus.host_we) begin
        bus.host_addr  = AW'($urandom_range(0, 63));
        bus.host_wdata = MW'($urandom);
      end
      bus.arb_enable = ($urandom_range(0, 9) != 0);
      cpu_step(4, 1'b1);
    end
    bus.host_we    = 1'b0;
    bus.arb_enable = 1'b1;
    step_n(20, 0, 1'b0);
    tick();
    tick();
    chk("sb_drained", 32'(q.size()), 32'd0);

    // Single-CPU build: held request granted every other cycle
    bus1.cpu_mem_addr = AW'(5);
    bus1.cpu_mem_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      chk("n1_ready", 32'(bus1.cpu_mem_ready), (t % 2 == 0) ? 32'd1 : 32'd0);
      if (t % 2 == 1) chk("n1_data", 32'(bus1.cpu_mem_data), 32'hBEEF);
    end
    bus1.cpu_mem_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
